// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W      = 8;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } arb_state_t;

    // Width of an index into n requesters, never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      start;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_done;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    modport master (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, start, tx_data, grant, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, start, tx_data, grant, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// i_ptr, wrapping around; o_grant is one-hot, o_any flags a winner.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_any
);

    logic [PTR_W-1:0] w_idx;

    // Scan ptr+1 .. ptr+N modulo N and keep the first hit.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = PTR_W'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// sources. Optional message lock: define UART_ARB_LOCK_EN to keep the
// grant on one requester until it sends a byte flagged req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    arb_state_t         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_start;
    logic [NUM_REQ-1:0] r_ready;
    logic [NUM_REQ-1:0] r_grant;
    logic [BYTE_W-1:0]  r_tx_data;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_win;
    logic               w_any;
    logic [BYTE_W-1:0]  w_data;
    logic [PTR_W-1:0]   w_idx;

`ifdef UART_ARB_LOCK_EN
    logic               r_lock;
    logic [NUM_REQ-1:0] r_owner;
    logic               w_last;

    // While locked only the owning requester is eligible.
    assign w_req  = r_lock ? (bus.req_valid & r_owner) : bus.req_valid;
    assign w_last = |(bus.req_last & w_win);
`else
    logic w_unused_last;

    assign w_req         = bus.req_valid;
    assign w_unused_last = ^bus.req_last;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_win),
        .o_any   (w_any)
    );

    // Encode the winner and select its byte.
    always_comb begin
        w_data = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_data = bus.req_data[i*BYTE_W +: BYTE_W];
                w_idx  = PTR_W'(i);
            end
        end
    end

    // Arbitration FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= PTR_W'(NUM_REQ - 1);
            r_start   <= 1'b0;
            r_ready   <= '0;
            r_grant   <= '0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            r_lock    <= 1'b0;
            r_owner   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state   <= START;
                        r_grant   <= w_win;
                        r_tx_data <= w_data;
                        r_start   <= 1'b1;
                        r_ready   <= w_win;
                        r_busy    <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                        // Pointer only moves once the message is complete.
                        if (w_last) begin
                            r_ptr  <= w_idx;
                            r_lock <= 1'b0;
                        end else begin
                            r_lock  <= 1'b1;
                            r_owner <= w_win;
                        end
`else
                        r_ptr     <= w_idx;
`endif
                    end
                end
                START: begin
                    r_start <= 1'b0;
                    r_ready <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.start     = r_start;
    assign bus.req_ready = r_ready;
    assign bus.grant     = r_grant;
    assign bus.tx_data   = r_tx_data;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based requesters, a
// transmitter with random frame length, and a transaction-level model of
// round-robin service. Honours UART_ARB_LOCK_EN when defined.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vec = 0;
    int mis = 0;

    // Per-requester byte queues: bit 8 = last-of-message flag.
    logic [8:0] q [N][$];
    logic [7:0] sent [$];

    // Reference model of the shared link.
    int         m_last  = N - 1;   // most recently served requester
    bit         m_lock  = 1'b0;
    int         m_owner = 0;
    int         phase   = 0;       // 0 link free, 1 byte launched, 2 frame on wire
    logic       exp_start;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_grant = '0;
    logic       exp_busy;
    logic [7:0] exp_data = '0;
    int         tx_cnt = 0;
    bit         stray_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Next requester to be served given the pending set.
    function automatic int pick(input logic [N-1:0] v);
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                logic [8:0] e;
                e = q[i][0];
                bus.req_valid[i]       = 1'b1;
                bus.req_data[i*8 +: 8] = e[7:0];
                bus.req_last[i]        = e[8];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[i*8 +: 8] = 8'h00;
                bus.req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] v_valid;
        logic         v_done;
        logic         v_rst;
        int           g;
        v_valid = bus.req_valid;
        v_done  = bus.tx_done;
        v_rst   = reset;
        @(posedge clk);
        #1;
        exp_start = 1'b0;
        exp_ready = '0;
        if (v_rst) begin
            phase = 0; exp_grant = '0; exp_data = '0;
            m_last = N - 1; m_lock = 1'b0; tx_cnt = 0;
        end else if (phase == 0) begin
            g = pick(v_valid);
            if (g >= 0) begin
                logic [8:0] e;
                e = q[g][0];
                exp_start = 1'b1;
                exp_ready = N'(1) << g;
                exp_grant = N'(1) << g;
                exp_data  = e[7:0];
                phase     = 1;
`ifdef UART_ARB_LOCK_EN
                if (e[8]) begin m_lock = 1'b0; m_last = g; end
                else begin m_lock = 1'b1; m_owner = g; end
`else
                m_last = g;
`endif
            end
        end else if (phase == 1) begin
            phase = 2;
        end else if (v_done) begin
            phase = 0;
            exp_grant = '0;
        end
        exp_busy = (phase != 0);
        check("start", 32'(bus.start), 32'(exp_start));
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("grant", 32'(bus.grant), 32'(exp_grant));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("tx_data", 32'(bus.tx_data), 32'(exp_data));
        if (bus.start === 1'b1) sent.push_back(bus.tx_data);
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i] === 1'b1 && q[i].size() > 0) void'(q[i].pop_front());
        bus.tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) bus.tx_done = 1'b1;
        end
        if (bus.start === 1'b1) begin
            tx_cnt = $urandom_range(2, 6);
            if (stray_en && $urandom_range(0, 3) == 0) bus.tx_done = 1'b1;
        end else if (tx_cnt == 0 && phase == 0 && stray_en && $urandom_range(0, 9) == 0) begin
            bus.tx_done = 1'b1;
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c;
        bit pend;
        c = 0;
        pend = 1'b1;
        while (pend && c < maxc) begin
            pend = (phase != 0) || (tx_cnt != 0);
            for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1'b1;
            if (pend) begin tick(); c++; end
        end
        check("drain_bound", 32'(pend), 32'(0));
    endtask

    initial begin
        logic [7:0] exp6 [4];
        int c;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_done   = 1'b0;
        do_reset(2);

        // Single request from requester 0.
        sent.delete();
        q[0].push_back({1'b1, 8'h41});
        drive();
        drain(100);
        check("single_cnt", sent.size(), 1);
        check("single_byte", 32'(sent[0]), 32'h41);

        // All four requesting, two bytes each: strict rotation.
        do_reset(1);
        sent.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h30 + i)});
        drive();
        drain(400);
        check("rr_cnt", sent.size(), 8);
        for (int i = 0; i < 8; i++) check("rr_order", 32'(sent[i]), 32'(8'h30 + (i % 4)));

        // Last served was requester 3: wrap to 0 before 2.
        sent.delete();
        q[2].push_back({1'b1, 8'h52});
        q[0].push_back({1'b1, 8'h50});
        drive();
        drain(100);
        check("wrap_first", 32'(sent[0]), 32'h50);
        check("wrap_second", 32'(sent[1]), 32'h52);

        // Stray tx_done in IDLE and in START.
        sent.delete();
        bus.tx_done = 1'b1;
        tick();
        q[1].push_back({1'b1, 8'h61});
        drive();
        tick();
        bus.tx_done = 1'b1;
        tick();
        drain(100);
        check("stray_cnt", sent.size(), 1);
        check("stray_byte", 32'(sent[0]), 32'h61);

        // Reset while a frame is in flight.
        q[2].push_back({1'b1, 8'h72});
        drive();
        c = 0;
        while (bus.start !== 1'b1 && c < 20) begin tick(); c++; end
        check("rst_launch_bound", 32'(c < 20), 32'(1));
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sent.delete();
        q[1].push_back({1'b1, 8'h81});
        q[0].push_back({1'b1, 8'h80});
        drive();
        drain(100);
        check("rst_first", 32'(sent[0]), 32'h80);
        check("rst_second", 32'(sent[1]), 32'h81);

        // Message "HI\n" from requester 1 competing with requester 0.
        do_reset(1);
        q[0].push_back({1'b1, 8'h5A});
        drive();
        drain(100);
        sent.delete();
        q[1].push_back({1'b0, 8'h48});
        q[1].push_back({1'b0, 8'h49});
        q[1].push_back({1'b1, 8'h0A});
        q[0].push_back({1'b1, 8'h5A});
        drive();
        drain(200);
`ifdef UART_ARB_LOCK_EN
        exp6[0] = 8'h48; exp6[1] = 8'h49; exp6[2] = 8'h0A; exp6[3] = 8'h5A;
`else
        exp6[0] = 8'h48; exp6[1] = 8'h5A; exp6[2] = 8'h49; exp6[3] = 8'h0A;
`endif
        check("msg_cnt", sent.size(), 4);
        for (int i = 0; i < 4; i++) check("msg_order", 32'(sent[i]), 32'(exp6[i]));

        // Random traffic with stray completions.
        stray_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(0, 3) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (q[r].size() < 3) q[r].push_back({1'($urandom_range(0, 1)), 8'($urandom)});
                drive();
            end
        end
        for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'($urandom)});
        drive();
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (`top_uart`: `start`, `tx_data`, `tx_done`) among up to `NUM_REQ` byte sources, such as the ASCII button sender and status/debug generators. A round-robin arbiter selects one pending requester and launches one byte with a single-cycle `start` pulse. It then waits for the transmitter's `tx_done` before serving the next byte. The block sits between the requesters and `top_uart`, replacing the direct `ascii_send` → `top_uart` connection.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: bit i is high while requester i has a byte pending.
- `req_data` input NUM_REQ*8: byte of requester i at bits [8i+7:8i].
- `req_last` input NUM_REQ: bit i marks the final byte of a message; used only with `UART_ARB_LOCK_EN`.
- `req_ready` output NUM_REQ: one-cycle accept pulse to the granted requester.
- `start` output 1: one-cycle pulse to `top_uart.start`.
- `tx_data` output 8: byte to `top_uart.tx_data`; held stable from `start` until `tx_done`.
- `tx_done` input 1: one-cycle completion pulse from `top_uart.o_tx_done`.
- `grant` output NUM_REQ: one-hot owner of the transmitter; zero when idle.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT_DONE.
- IDLE:
  - If any `req_valid` bit is set, pick requester g, scanning from index `ptr+1` upward with wrap-around.
  - Register `grant`=1<<g and capture `req_data[g]` into `tx_data`, then go to START.
  - If no `req_valid` bit is set, stay in IDLE.
- START (exactly one cycle): `start`=1 and `req_ready[g]`=1, then go to WAIT_DONE.
- WAIT_DONE: hold `tx_data` and `grant`. On `tx_done`=1, clear `grant` and go to IDLE.
- Round-robin pointer `ptr`:
  - Set to g when entering START.
  - Reset value is NUM_REQ-1, so requester 0 has first priority after reset.
- Requester rules:
  - Hold `req_valid`/`req_data` stable until `req_ready` is seen.
  - The byte is consumed on the `req_ready` cycle.
  - Deasserting `req_valid` before `req_ready` is illegal; the byte captured in IDLE is sent regardless.
- `tx_done` outside WAIT_DONE is ignored.
- Simultaneous requests: exactly one grant; the others wait with no loss.
- Reset mid-operation:
  - Return to IDLE and clear `grant`, `start`, `req_ready`, `tx_data`, `busy`.
  - Set `ptr`=NUM_REQ-1.
  - The same `reset` also resets `top_uart`, so the partial frame is abandoned.
- Reset values: all outputs 0.

## Timing
- `req_valid` sampled high in IDLE at cycle T → `start` and `req_ready` at T+1.
- `tx_done` at cycle D → IDLE at D+1 → next `start` no earlier than D+2.
- Sustained throughput: one byte per UART frame plus 2 cycles of overhead.
- `busy` rises at T+1 and falls at D+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `UART_ARB_LOCK_EN` defined (message lock):
  - After sending a byte with `req_last`=0, IDLE re-grants the same requester and other requesters are not considered.
  - The lock lasts until a byte with `req_last`=1 is sent; `ptr` advances only on that byte.
  - While locked and the owner's `req_valid`=0, the FSM idles in IDLE with `busy`=0 and keeps the lock.
- Not defined:
  - `req_last` is ignored.
  - Every byte is arbitrated independently, so bytes from different requesters interleave.

## Structure
- Package `uart_arb_pkg`:
  - state enum (IDLE/START/WAIT_DONE)
  - `BYTE_W`=8
  - `NUM_REQ_MAX`=8
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: request vector, `ptr`. Outputs: one-hot winner, `any`.
  - Reused by future shared-resource arbiters.
- Top file `uart_tx_arbiter`: FSM, data/grant registers, pointer, lock flag.

## Test plan
- Single request: after reset, `req_valid`=0001 with data 0x41 → `start`+`req_ready[0]` one cycle later, `tx_data`=0x41 until `tx_done`, then `busy`=0.
- Simultaneous requests: `req_valid`=1111 held, data 0x30..0x33 → bytes sent in order 0x30, 0x31, 0x32, 0x33, then 0x30; each `start` exactly 2 cycles after the previous `tx_done`.
- Pointer wrap: `ptr`=3 with requests 0 and 2 pending → requester 0 is granted first.
- Stray `tx_done`: pulse during IDLE and START → no state change and no extra `req_ready`.
- Reset in WAIT_DONE: assert `reset` mid-frame → next cycle all outputs 0, then requester 0 is served first.
- Lock (`UART_ARB_LOCK_EN`): requester 1 sends "HI\n" with `req_last` only on '\n' while requester 0 is pending → 'H', 'I', '\n' go out contiguously before requester 0's byte. Without the macro, requester 0's byte interleaves after 'H'.
